// File: rtl/avmm_cfg_seq_master.sv
// rtl/avmm_cfg_seq_master.sv - queued Avalon-MM configuration master with per-command timeout
module avmm_cfg_seq_master #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avmm_address,
  output logic [DATA_W-1:0] avmm_writedata,
  output logic [BE_W-1:0]   avmm_byteenable,
  output logic              avmm_write,
  output logic              avmm_read,
  input  logic              avmm_waitrequest,
  input  logic [DATA_W-1:0] avmm_readdata,
  input  logic              avmm_readdatavalid
);

  localparam int AW      = $clog2(CMD_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + BE_W;
  localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TMO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDV, RESP} state_t;

  state_t state, state_nxt;

  logic [ENTRY_W-1:0] mem [CMD_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, empty, push, pop;
  logic               head_write;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [BE_W-1:0]    head_be;

  logic [CNT_W-1:0]   tmo_cnt;
  logic               cur_write;
  logic               accept, rdv_hit, tmo_hit;

  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d, rdata_d;
  logic [BE_W-1:0]    be_d;
  logic               wr_d, rd_d, cur_write_d;
  logic               rsp_valid_d, rsp_write_d, rsp_error_d;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = !empty || (state != IDLE);

  assign {head_write, head_addr, head_data, head_be} = mem[rd_ptr[AW-1:0]];

  // Completion wins over a timeout that lands in the same cycle.
  assign accept  = (state == ISSUE) && !avmm_waitrequest;
  assign rdv_hit = (state == WAIT_RDV) && avmm_readdatavalid;
  assign tmo_hit = TMO_EN && ((state == ISSUE) || (state == WAIT_RDV)) &&
                   !accept && !rdv_hit && (tmo_cnt == TMO_LAST);

  // Command FIFO storage; entries carry no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_write, cmd_addr, cmd_data, cmd_be};
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Bus-time counter: cleared when a command enters ISSUE, counts while it is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (pop) begin
      tmo_cnt <= '0;
    end else if ((state == ISSUE) || (state == WAIT_RDV)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // State register together with the registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cur_write       <= 1'b0;
      avmm_address    <= '0;
      avmm_writedata  <= '0;
      avmm_byteenable <= '0;
      avmm_write      <= 1'b0;
      avmm_read       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
    end else begin
      state           <= state_nxt;
      cur_write       <= cur_write_d;
      avmm_address    <= addr_d;
      avmm_writedata  <= wdata_d;
      avmm_byteenable <= be_d;
      avmm_write      <= wr_d;
      avmm_read       <= rd_d;
      rsp_valid       <= rsp_valid_d;
      rsp_write       <= rsp_write_d;
      rsp_rdata       <= rdata_d;
      rsp_error       <= rsp_error_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pop) state_nxt = ISSUE;
      ISSUE: begin
        if (accept)       state_nxt = cur_write ? RESP : WAIT_RDV;
        else if (tmo_hit) state_nxt = RESP;
      end
      WAIT_RDV: if (rdv_hit || tmo_hit) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the bus is parked at zero whenever no strobe is up.
  always_comb begin
    addr_d      = '0;
    wdata_d     = '0;
    be_d        = '0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    cur_write_d = cur_write;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_error_d = 1'b0;
    rdata_d     = '0;
    case (state)
      IDLE: begin
        if (pop) begin
          addr_d      = head_addr;
          wdata_d     = head_data;
          be_d        = head_be;
          wr_d        = head_write;
          rd_d        = !head_write;
          cur_write_d = head_write;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (cur_write) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
          end
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write;
          rsp_error_d = 1'b1;
        end else begin
          addr_d  = avmm_address;
          wdata_d = avmm_writedata;
          be_d    = avmm_byteenable;
          wr_d    = avmm_write;
          rd_d    = avmm_read;
        end
      end
      WAIT_RDV: begin
        if (rdv_hit) begin
          rsp_valid_d = 1'b1;
          rdata_d     = avmm_readdata;
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
